// File: rtl/clk_div_multi_if.sv
// Divisor write port of clk_div_multi: write strobe, target channel,
// new divisor, and the one-cycle reject flag returned by the divider.
interface clk_div_multi_if #(
  parameter int NCH = 4,
  parameter int CW  = 18
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0]  wr_div;
  logic           wr_err;

  // Master side issues writes and observes rejects.
  modport master (
    output wr_en,
    output wr_ch,
    output wr_div,
    input  wr_err
  );

  // Slave side (the divider) accepts writes and reports rejects.
  modport slave (
    input  wr_en,
    input  wr_ch,
    input  wr_div,
    output wr_err
  );

endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider running on clk_50mhz.
// Every channel owns a counter, an active divisor and a shadow (pending)
// divisor. The shadow is only copied into the active divisor at a period
// boundary (start, wrap or sync), so a runtime divisor change never cuts a
// period short. All outputs come straight from flops.
module clk_div_multi #(
  parameter int NCH         = 4,
  parameter int CW          = 18,
  parameter int DEFAULT_DIV = 200000,
  parameter int STOP_MODE   = 0
) (
  input  logic           clk_50mhz,
  input  logic           rst_n,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  clk_div_multi_if.slave wr_bus,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] running
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam bit DEF_OK = (DEFAULT_DIV >= 32'sd2) &&
                          ((64'(DEFAULT_DIV) >> CW) == 64'd0);
  localparam bit NCH_OK = (NCH >= 32'sd1) && (NCH <= 32'sd16);

  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0] DIV_MIN = CW'(32'd2);
  localparam logic [CW-1:0] DEF_DIV = CW'(DEFAULT_DIV);
  localparam logic [CW-1:0] DEF_CNT = DEF_DIV - CNT_ONE;

  localparam bit STOP_NOW = (STOP_MODE == 32'sd0);

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Elaboration-time guards on the parameter set.
  if (!DEF_OK) begin : g_bad_default
    $error("clk_div_multi: DEFAULT_DIV must be >= 2 and fit in CW bits");
  end
  if (!NCH_OK) begin : g_bad_nch
    $error("clk_div_multi: NCH must be in 1..16");
  end

  // ---------------------------------------------------------------------
  // Write port decode
  // ---------------------------------------------------------------------
  logic ch_ok_s;
  logic div_ok_s;
  logic wr_acc_s;
  logic wr_err_r;

  // When NCH fills the whole channel field every encoding is a real channel.
  if ((1 << CHW) == NCH) begin : g_ch_full
    assign ch_ok_s = 1'b1;
  end else begin : g_ch_part
    localparam logic [CHW-1:0] CH_LIMIT = CHW'(NCH);
    assign ch_ok_s = (wr_bus.wr_ch < CH_LIMIT);
  end

  assign div_ok_s = (wr_bus.wr_div >= DIV_MIN);
  assign wr_acc_s = wr_bus.wr_en & ch_ok_s & div_ok_s;

  // Reject flag: high for the one cycle after a write that was not taken.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_bus.wr_en & ~(ch_ok_s & div_ok_s);
    end
  end

  assign wr_bus.wr_err = wr_err_r;

  // ---------------------------------------------------------------------
  // Divider channels
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam int unsigned    IDX   = gi;
    localparam logic [CHW-1:0] CH_ID = CHW'(IDX);

    ch_state_e     state_r;
    ch_state_e     state_n;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] act_r;
    logic [CW-1:0] act_n;
    logic [CW-1:0] pend_r;
    logic [CW-1:0] pend_n;
    logic [CW-1:0] last_s;
    logic          wrap_s;
    logic          run_n;
    logic          clk_n;
    logic          tick_n;
    logic          clk_out_r;
    logic          tick_r;
    logic          running_r;

    // Next counter/divisor/state: start, wrap, sync, stop and drain rules.
    always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      act_n   = act_r;
      last_s  = act_r - CNT_ONE;
      wrap_s  = (cnt_r == last_s);
      case (state_r)
        CH_IDLE: begin
          if (en[gi]) begin
            // Starting (with or without sync) always opens a fresh period.
            state_n = CH_RUN;
            cnt_n   = '0;
            act_n   = pend_r;
          end else begin
            state_n = CH_IDLE;
            cnt_n   = cnt_r;
          end
        end
        CH_RUN: begin
          if (!en[gi] && STOP_NOW) begin
            // Immediate stop: park at the last count of the active divisor.
            state_n = CH_IDLE;
            cnt_n   = last_s;
          end else if (!en[gi] && wrap_s) begin
            // Draining channel ends at its wrap even if sync arrives.
            state_n = CH_IDLE;
            cnt_n   = last_s;
          end else if (sync || wrap_s) begin
            cnt_n = '0;
            act_n = pend_r;
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_n = CH_IDLE;
          cnt_n   = last_s;
        end
      endcase
    end

    // Next shadow divisor and the output values that go with the next state.
    always_comb begin
      if (wr_acc_s && (wr_bus.wr_ch == CH_ID)) begin
        pend_n = wr_bus.wr_div;
      end else begin
        pend_n = pend_r;
      end
      run_n  = (state_n == CH_RUN);
      clk_n  = run_n && (cnt_n < (act_n >> 1'b1));
      tick_n = run_n && (cnt_n == (act_n - CNT_ONE));
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
        state_r   <= CH_IDLE;
        cnt_r     <= DEF_CNT;
        act_r     <= DEF_DIV;
        pend_r    <= DEF_DIV;
        clk_out_r <= 1'b0;
        tick_r    <= 1'b0;
        running_r <= 1'b0;
      end else begin
        state_r   <= state_n;
        cnt_r     <= cnt_n;
        act_r     <= act_n;
        pend_r    <= pend_n;
        clk_out_r <= clk_n;
        tick_r    <= tick_n;
        running_r <= run_n;
      end
    end

    assign clk_out[gi] = clk_out_r;
    assign tick[gi]    = tick_r;
    assign running[gi] = running_r;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider for clk_50mhz.
- Each channel produces a registered square wave and a one-cycle tick strobe.
- Divisors can be changed at runtime and take effect glitch-free at the period boundary.
- Feeds display scanning, debounce, and timebase logic that currently use fixed dividers. Channels can be phase-aligned with a common sync pulse.

Parameters:
- NCH, 4, number of independent divider channels (1..16).
- CW, 18, counter/divisor width in bits.
- DEFAULT_DIV, 200000, divisor loaded into every channel at reset (250 Hz from 50 MHz).
- STOP_MODE, 0, behaviour when en drops: 0 = stop immediately, 1 = finish the current period and then stop.

Ports:
- clk_50mhz  in   1              system clock, 50 MHz.
- rst_n      in   1              asynchronous reset, active-low.
- en         in   NCH            per-channel run enable, level.
- sync       in   1              one-cycle pulse that restarts all running channels at count 0.
- wr_en      in   1              divisor write strobe.
- wr_ch      in   max(1,$clog2(NCH))  target channel for the write.
- wr_div     in   CW             new divisor, in clk cycles per output period.
- wr_err     out  1              one-cycle pulse: previous-cycle write was rejected.
- clk_out    out  NCH            per-channel divided square wave.
- tick       out  NCH            per-channel strobe, high during the last cycle of each period.
- running    out  NCH            per-channel status: channel counting.

Behaviour:
- Reset is asynchronous on rst_n and only on rst_n.
- Per-channel state:
  - cnt[CW]
  - active_div (divisor in use)
  - pending_div (shadow)
  - run flag
- Reset values:
  - active_div = pending_div = DEFAULT_DIV
  - cnt = DEFAULT_DIV-1 (parked)
  - run = 0
  - clk_out = 0, tick = 0, running = 0, wr_err = 0
- Outputs are registered. After every edge:
  - clk_out_i = run_i && (cnt_i < active_div_i>>1)
  - tick_i = run_i && (cnt_i == active_div_i-1)
  - running_i = run_i
- Odd divisor D: output is high for floor(D/2) cycles and low for ceil(D/2) cycles.
- Channel states and transitions:
  - IDLE (run=0, cnt parked at active_div-1): if en_i=1 at an edge, then run=1, active_div<=pending_div, cnt<=0. clk_out goes high in that same edge's outputs, which is 1 cycle of latency from en.
  - RUN: at each edge, if cnt==active_div-1, wrap: cnt<=0 and active_div<=pending_div. Otherwise cnt<=cnt+1.
  - RUN with en_i=0 and STOP_MODE=0: next edge goes to IDLE with cnt<=active_div-1. clk_out and tick are 0 from that edge.
  - RUN with en_i=0 and STOP_MODE=1 (DRAIN): keep counting. At the wrap edge go to IDLE instead of cnt<=0. The tick for the final cycle is still emitted.
  - DRAIN with en_i re-asserted before the wrap: the channel stays running and wraps normally.
- sync=1 at an edge: every channel that is running, or starting from IDLE at that edge, sets cnt<=0 and active_div<=pending_div. IDLE channels with en=0 are unaffected. sync overrides wrap and drain, but a draining channel still stops at its wrap.
- Write port:
  - Accepted when wr_en=1, wr_ch<NCH and wr_div>=2: pending_div[wr_ch]<=wr_div at that edge.
  - Otherwise rejected: pending is unchanged and wr_err=1 for exactly the next cycle.
  - A write on the same edge as a wrap, sync, or start is not used by that event. It applies at the following boundary.
  - A write to an IDLE channel is applied when the channel next starts.
  - Back-to-back writes: the last accepted value wins.
- Divisor change never shortens or truncates the current period.
- cnt never exceeds active_div-1. No output glitches, because all outputs are flops.
- Width rules:
  - cnt and divisors are unsigned CW bits.
  - The compare uses active_div-1 computed in CW bits; wr_div>=2 guarantees no underflow.
  - DEFAULT_DIV must fit in CW bits and be >=2. This is checked at elaboration.
- Mid-operation rst_n assertion: all channels go to the reset state immediately, and pending writes are lost.

Test Plan:
1. Reset, then write ch0 div=4 and ch1 div=5, then en=0011 -> ch0 clk_out is 1100 repeating with tick on the 4th cycle. ch1 clk_out is 11000 with tick on the 5th cycle. Both go high 1 cycle after en.
2. ch0 running div=4; write div=6 mid-period -> current 4-cycle period completes unchanged, then the 111000 pattern starts. Repeat with the write on the wrap edge -> the 6 takes effect one period later.
3. Write wr_ch=NCH (out of range), then wr_div=1, then wr_div=0 -> wr_err pulses 1 cycle each. Pending divisors are unchanged and outputs are undisturbed.
4. ch0 div=8 and ch1 div=3 running; pulse sync -> both have cnt=0 the next cycle and clk_out rising together. An IDLE ch2 with en=0 stays low.
5. STOP_MODE=0: drop en at cnt=2 of div=8 -> running and clk_out are 0 the next cycle. STOP_MODE=1: same stimulus -> counting continues, tick fires at cnt=7, then running=0. Re-raising en during the drain keeps the channel running.
6. Default divisor, en=1 -> clk_out period is 200000 cycles (100000 high), tick every 200000 cycles. Assert rst_n mid-period -> all outputs are 0 immediately and the divisor returns to DEFAULT_DIV.
